// File: rtl/data_bus_mmio_pkg.sv
// Shared SoC definitions for the data-side bus stage: MMIO window base,
// register offsets, STATUS bit positions and UART transmitter state encodings.
package data_bus_mmio_pkg;

    localparam logic [15:0] MMIO_BASE_DEF    = 16'hFFFF;
    localparam logic [15:0] BAUD_DIV_RST_DEF = 16'd434;

    localparam logic [15:0] OFF_TXDATA = 16'h0000;
    localparam logic [15:0] OFF_STATUS = 16'h0004;
    localparam logic [15:0] OFF_CYCLES = 16'h0008;
    localparam logic [15:0] OFF_BAUD   = 16'h000C;

    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // A programmed divider of zero behaves as one cycle per bit.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/data_bus_mmio_uart_tx.sv
// 8N1 UART transmitter: takes one byte per valid/ready handshake in IDLE and
// holds each of start, 8 data bits (LSB first) and stop for div cycles.
module data_bus_mmio_uart_tx
    import data_bus_mmio_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [7:0]  byte_i,
    input  logic [15:0] div_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic        txd_o
);

    tx_state_e   state_q;
    logic [15:0] cnt_q;
    logic [15:0] div_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic        txd_q;

    assign ready_o = (state_q == TX_IDLE);
    assign busy_o  = (state_q != TX_IDLE);
    assign txd_o   = txd_q;

    // Frame sequencer; divider is captured at pop so mid-frame writes wait a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TX_IDLE;
            cnt_q   <= 16'd0;
            div_q   <= 16'd1;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            txd_q   <= 1'b1;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    if (valid_i) begin
                        shift_q <= byte_i;
                        div_q   <= div_i;
                        cnt_q   <= div_i - 16'd1;
                        txd_q   <= 1'b0;
                        state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (cnt_q == 16'd0) begin
                        cnt_q   <= div_q - 16'd1;
                        bit_q   <= 3'd0;
                        txd_q   <= shift_q[0];
                        state_q <= TX_DATA;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (cnt_q == 16'd0) begin
                        cnt_q <= div_q - 16'd1;
                        if (bit_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= TX_STOP;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            txd_q   <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (cnt_q == 16'd0) begin
                        state_q <= TX_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= TX_IDLE;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/data_bus_mmio.sv
// Data-side bus stage: routes CPU data accesses to RAM or to the MMIO window
// holding the UART TX FIFO, the free-running cycle counter and the baud divider.
module data_bus_mmio
    import data_bus_mmio_pkg::*;
#(
    parameter logic [15:0] MMIO_BASE    = MMIO_BASE_DEF,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [15:0] BAUD_DIV_RST = BAUD_DIV_RST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memCe,
    input  logic        memWr,
    input  logic [31:0] memAddr,
    input  logic [31:0] wtData,
    output logic [31:0] rdData,
    output logic        ramCe,
    output logic        ramWe,
    output logic [31:0] ramAddr,
    output logic [31:0] ramWtData,
    input  logic [31:0] ramRdData,
    output logic        txd
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic             mmio_sel_s, mmio_wr_s;
    logic [15:0]      offset_s;
    logic             wr_txdata_s, wr_status_s, wr_baud_s;
    logic             fifo_empty_s, fifo_full_s, push_ok_s, pop_s;
    logic             tx_ready_s, tx_busy_s;
    logic [31:0]      status_s, reg_rd_s;

    logic [7:0]       fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [31:0]      cycles_q;
    logic [15:0]      baud_q;

    assign offset_s     = memAddr[15:0];
    assign mmio_sel_s   = memCe & (memAddr[31:16] == MMIO_BASE);
    assign mmio_wr_s    = mmio_sel_s & memWr;
    assign ramCe        = memCe & ~mmio_sel_s;
    assign ramWe        = ramCe & memWr;
    assign ramAddr      = memAddr;
    assign ramWtData    = wtData;

    assign wr_txdata_s  = mmio_wr_s & (offset_s == OFF_TXDATA);
    assign wr_status_s  = mmio_wr_s & (offset_s == OFF_STATUS);
    assign wr_baud_s    = mmio_wr_s & (offset_s == OFF_BAUD);

    assign fifo_empty_s = (count_q == CNT_W'(0));
    assign fifo_full_s  = (count_q == CNT_W'(FIFO_DEPTH));
    assign push_ok_s    = wr_txdata_s & ~fifo_full_s;
    assign pop_s        = ~fifo_empty_s & tx_ready_s;

    // FIFO occupancy and sticky overflow next-state.
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (wr_txdata_s && fifo_full_s) begin
            overflow_d = 1'b1;
        end else if (wr_status_s) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Register read mux and final CPU read data select.
    always_comb begin
        status_s               = 32'd0;
        status_s[STAT_EMPTY]   = fifo_empty_s;
        status_s[STAT_FULL]    = fifo_full_s;
        status_s[STAT_BUSY]    = tx_busy_s;
        status_s[STAT_OVF]     = overflow_q;
        status_s[STAT_CNT_LSB +: 4] = 4'(count_q);
        case (offset_s)
            OFF_STATUS: reg_rd_s = status_s;
            OFF_CYCLES: reg_rd_s = cycles_q;
            OFF_BAUD:   reg_rd_s = {16'd0, baud_q};
            default:    reg_rd_s = 32'd0;
        endcase
        if (mmio_sel_s) begin
            rdData = reg_rd_s;
        end else if (ramCe) begin
            rdData = ramRdData;
        end else begin
            rdData = 32'd0;
        end
    end

    // FIFO storage; stale entries are harmless because pointers reset.
    always_ff @(posedge clk) begin
        if (push_ok_s && !rst) begin
            fifo_mem_q[wr_ptr_q] <= wtData[7:0];
        end
    end

    // Pointers, occupancy, overflow, cycle counter and baud divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            cycles_q   <= 32'd0;
            baud_q     <= BAUD_DIV_RST;
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q    <= count_d;
            overflow_q <= overflow_d;
            cycles_q   <= cycles_q + 32'd1;
            if (wr_baud_s) begin
                baud_q <= wtData[15:0];
            end
        end
    end

    data_bus_mmio_uart_tx u_uart_tx (
        .clk     (clk),
        .rst     (rst),
        .valid_i (~fifo_empty_s),
        .byte_i  (fifo_mem_q[rd_ptr_q]),
        .div_i   (eff_div(baud_q)),
        .ready_o (tx_ready_s),
        .busy_o  (tx_busy_s),
        .txd_o   (txd)
    );

endmodule

// File: tb/tb_data_bus_mmio.sv
// Directed self-checking bench for data_bus_mmio: RAM pass-through, UART
// framing, FIFO overflow, cycle counter, mid-frame reset and unmapped access.
module tb_data_bus_mmio;

    logic        clk = 1'b0;
    logic        rst;
    logic        memCe, memWr;
    logic [31:0] memAddr, wtData, rdData;
    logic        ramCe, ramWe;
    logic [31:0] ramAddr, ramWtData, ramRdData;
    logic        txd;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] A_TX   = 32'hFFFF_0000;
    localparam logic [31:0] A_STAT = 32'hFFFF_0004;
    localparam logic [31:0] A_CYC  = 32'hFFFF_0008;
    localparam logic [31:0] A_BAUD = 32'hFFFF_000C;
    localparam logic [31:0] A_UNM  = 32'hFFFF_0020;

    data_bus_mmio dut (
        .clk       (clk),
        .rst       (rst),
        .memCe     (memCe),
        .memWr     (memWr),
        .memAddr   (memAddr),
        .wtData    (wtData),
        .rdData    (rdData),
        .ramCe     (ramCe),
        .ramWe     (ramWe),
        .ramAddr   (ramAddr),
        .ramWtData (ramWtData),
        .ramRdData (ramRdData),
        .txd       (txd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; the write commits on the following posedge.
    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
        memCe = 1'b1; memWr = 1'b1; memAddr = addr; wtData = data;
        @(negedge clk);
        memCe = 1'b0; memWr = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data);
        memCe = 1'b1; memWr = 1'b0; memAddr = addr;
        #1 data = rdData;
        memCe = 1'b0;
    endtask

    logic [31:0] v, v2;
    logic [7:0]  tx_byte;
    logic        exp_bit;
    logic        low_seen;

    initial begin
        rst = 1'b1; memCe = 1'b0; memWr = 1'b0; memAddr = 32'd0;
        wtData = 32'd0; ramRdData = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state
        chk("rst_txd", {31'd0, txd}, 32'd1);
        bus_rd(A_STAT, v); chk("rst_status", v, 32'h01);
        bus_rd(A_BAUD, v); chk("rst_baud", v, 32'd434);
        bus_rd(A_CYC, v);  chk("rst_cycles", v, 32'd0);

        // 1. RAM pass-through
        memCe = 1'b1; memWr = 1'b1; memAddr = 32'h10; wtData = 32'hDEAD_BEEF;
        #1;
        chk("ram_wr_ctl", {30'd0, ramCe, ramWe}, 32'd3);
        chk("ram_wr_addr", ramAddr, 32'h10);
        chk("ram_wr_data", ramWtData, 32'hDEAD_BEEF);
        memWr = 1'b0; ramRdData = 32'h1234_5678;
        #1;
        chk("ram_rd_ctl", {30'd0, ramCe, ramWe}, 32'd2);
        chk("ram_rd_data", rdData, 32'h1234_5678);
        memCe = 1'b0;
        @(negedge clk);
        chk("ram_txd_idle", {31'd0, txd}, 32'd1);

        // 2. single byte at BAUD_DIV=4
        bus_wr(A_BAUD, 32'hABCD_0004);
        bus_rd(A_BAUD, v); chk("baud_rb", v, 32'd4);
        tx_byte = 8'h55;
        bus_wr(A_TX, {24'd0, tx_byte});
        chk("tx_pre_txd", {31'd0, txd}, 32'd1);
        bus_rd(A_STAT, v); chk("tx_pre_status", v, 32'h10);
        @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            if (k < 4)       exp_bit = 1'b0;
            else if (k < 36) exp_bit = tx_byte[(k - 4) / 4];
            else             exp_bit = 1'b1;
            chk($sformatf("tx_bit_%0d", k), {31'd0, txd}, {31'd0, exp_bit});
            bus_rd(A_STAT, v);
            chk($sformatf("tx_busy_%0d", k), {31'd0, v[2]}, 32'd1);
            @(negedge clk);
        end
        chk("tx_end_txd", {31'd0, txd}, 32'd1);
        bus_rd(A_STAT, v); chk("tx_end_status", v, 32'h01);

        // 3. FIFO overflow at BAUD_DIV=100
        bus_wr(A_BAUD, 32'd100);
        for (int i = 0; i < 6; i++) bus_wr(A_TX, 32'h30 + i);
        bus_rd(A_STAT, v); chk("ovf_status", v, 32'h4E);
        bus_wr(A_STAT, 32'd0);
        bus_rd(A_STAT, v); chk("ovf_clear", v, 32'h46);

        // 4. CYCLES
        bus_rd(A_CYC, v);
        repeat (5) @(negedge clk);
        bus_rd(A_CYC, v2);
        chk("cyc_delta", v2 - v, 32'd5);
        force dut.cycles_q = 32'hFFFF_FFFF;
        #1 release dut.cycles_q;
        bus_rd(A_CYC, v); chk("cyc_max", v, 32'hFFFF_FFFF);
        @(negedge clk);
        bus_rd(A_CYC, v); chk("cyc_wrap", v, 32'd0);

        // 5. reset mid-frame
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_wr(A_BAUD, 32'd4);
        bus_wr(A_TX, 32'hA5);
        bus_wr(A_TX, 32'h3C);
        bus_wr(A_TX, 32'h0F);
        repeat (16) @(negedge clk);
        chk("mid_bit3", {31'd0, txd}, 32'd0);
        bus_rd(A_STAT, v); chk("mid_status", v, 32'h24);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_txd", {31'd0, txd}, 32'd1);
        bus_rd(A_STAT, v); chk("mrst_status", v, 32'h01);
        bus_rd(A_BAUD, v); chk("mrst_baud", v, 32'd434);
        rst = 1'b0;
        low_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) low_seen = 1'b1;
        end
        chk("mrst_no_frame", {31'd0, low_seen}, 32'd0);
        bus_rd(A_STAT, v); chk("mrst_idle", v, 32'h01);

        // 6. unmapped and disabled access
        bus_rd(A_UNM, v); chk("unm_rd", v, 32'd0);
        memCe = 1'b1; memWr = 1'b0; memAddr = A_UNM;
        #1 chk("unm_ramce", {31'd0, ramCe}, 32'd0);
        memCe = 1'b0;
        bus_wr(A_UNM, 32'h0000_0077);
        bus_rd(A_STAT, v); chk("unm_status", v, 32'h01);
        bus_rd(A_BAUD, v); chk("unm_baud", v, 32'd434);
        repeat (3) @(negedge clk);
        chk("unm_txd", {31'd0, txd}, 32'd1);
        memCe = 1'b0; memWr = 1'b0; memAddr = 32'h10; ramRdData = 32'hCAFE_F00D;
        #1;
        chk("dis_rd", rdData, 32'd0);
        chk("dis_ramce", {31'd0, ramCe}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
